eq_arbiter_seq: RTL and testbench
=================================

# eq_arbiter_seq

Shared-comparator sequencer: accepts equality-compare requests from two requesters, arbitrates round-robin, and resolves each WIDTH-bit compare by time-multiplexing one 4-bit equality comparator (EQ4 function), one nibble per cycle, LSB nibble first. A mismatch ends the compare early. Used where several small clients need occasional wide equality checks and only one 4-bit comparator slice can be spent.

## Interface
- WIDTH, 16, operand width in bits; multiple of 4, ≥ 4; N = WIDTH/4 nibbles
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- REQ0_VALID  in  1  requester 0 has a compare pending
- REQ0_A, REQ0_B  in  WIDTH  requester 0 operands
- REQ0_READY  out  1  requester 0 request accepted this cycle
- REQ1_VALID, REQ1_A, REQ1_B, REQ1_READY  same as requester 0, for requester 1
- RES_VALID  out  1  one-cycle result strobe
- RES_EQ  out  1  1 = operands equal; valid only with RES_VALID
- RES_ID  out  1  requester that owns the result; valid only with RES_VALID
- BUSY  out  1  high in CMP and DONE

## Operation
- States: IDLE, CMP, DONE. Reset → IDLE, priority pointer = 0, nibble index = 0, all outputs 0.
- IDLE: if any REQx_VALID, grant winner; REQx_READY is combinational from state/VALID/pointer, high only for winner. Handshake = VALID & READY. On handshake:
  - latch A and B, set owner = x, index = 0, accumulator = 1, pointer = other requester, go to CMP.
- Arbitration: if only one valid, it wins; if both valid, the requester named by the pointer wins.
- CMP: the comparator sees nibble[index] of the latched A and B.
  - accumulator &= eq.
  - If eq = 0 or index = N-1, go to DONE; otherwise index += 1.
- DONE: RES_VALID = 1, RES_EQ = accumulator, RES_ID = owner; return to IDLE next cycle.
- No READY in CMP or DONE; new requests wait. Operands changed by the requester after its handshake do not affect the result.
- A requester may drop VALID before the grant with no effect. Requests are never lost once the handshake completes, except on RESET.

## Timing
- Handshake in cycle t: CMP occupies cycles t+1 … t+k, where k = (index of first mismatching nibble)+1, or N if all nibbles match. DONE / RES_VALID falls in cycle t+k+1.
- WIDTH=16: full match gives RES_VALID at t+5; mismatch in nibble 0 gives RES_VALID at t+2.
- Earliest next handshake is t+k+2 (IDLE after DONE), so back-to-back throughput is one compare per k+2 cycles.
- RES_VALID is high for exactly one cycle per accepted request. RES_EQ and RES_ID are 0 whenever RES_VALID is 0.
- RESET asserted in any state: the next cycle is IDLE with outputs 0 and pointer 0. An in-flight compare is discarded with no RES_VALID. READY can assert in the first cycle with RESET low.
- WIDTH=4: k = 1 always, so every result arrives at t+2.

## Test plan
- Single equal compare: REQ0 A=B=16'hABCD → READY in handshake cycle t, RES_VALID at t+5, RES_EQ=1, RES_ID=0, BUSY high t+1…t+5.
- Early exit: REQ1 A=16'h1234, B=16'h1235 → RES_VALID at t+2, RES_EQ=0, RES_ID=1. Then A=16'h1234, B=16'h9234 (top nibble only) → RES_VALID at t+5, RES_EQ=0.
- Fairness: after reset, hold both VALID continuously with equal operands → grants go 0,1,0,1. Each RES_ID matches its grant, and successive handshakes are 6 cycles apart.
- Operand stability: change REQ0_A to a mismatching value in the cycle after handshake → result still RES_EQ=1 for the latched equal operands.
- Reset mid-CMP: assert RESET at t+2 of a 16-bit compare → next cycle BUSY=0, RES_VALID never pulses for that request. With REQ1_VALID held, REQ1_READY asserts in the first cycle after RESET deasserts.
- WIDTH=4 build: A=4'h7, B=4'h7 → RES_EQ=1 at t+2. A=4'h7, B=4'h6 → RES_EQ=0 at t+2.

Source files
------------

// File: rtl/eq_arbiter_seq.sv
// eq_arbiter_seq: two-requester round-robin front end for one shared 4-bit
// equality slice. Each accepted compare is walked LSB nibble first and stops
// at the first mismatching nibble. The result is strobed for one cycle in DONE.

// One 4-bit equality slice: the only comparator hardware in the block.
module eq4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       eq_o
);
    assign eq_o = (a_i == b_i);
endmodule

module eq_arbiter_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             req1_ready_o,
    output logic             res_valid_o,
    output logic             res_eq_o,
    output logic             res_id_o,
    output logic             busy_o
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q,   ptr_d;    // requester favoured on a tie
    logic              owner_q, owner_d;  // requester that owns the compare
    logic              acc_q,   acc_d;    // running AND of nibble matches
    logic [IDXW-1:0]   idx_q,   idx_d;    // nibble currently on the slice
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;

    logic              gnt0, gnt1;
    logic [3:0]        nib_a, nib_b;
    logic              nib_eq;
    logic              last_nib;

    // Grants only exist in IDLE and never while reset is held, so a requester
    // cannot see a handshake that the reset would immediately discard.
    assign gnt0 = (state_q == S_IDLE) & ~reset_i & req0_valid_i
                & (~req1_valid_i | ~ptr_q);
    assign gnt1 = (state_q == S_IDLE) & ~reset_i & req1_valid_i
                & (~req0_valid_i |  ptr_q);

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // Route the indexed nibble of the latched operands onto the shared slice.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = a_q[i*4 +: 4];
                nib_b = b_q[i*4 +: 4];
            end
        end
    end

    eq4 u_eq4 (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .eq_o (nib_eq)
    );

    assign last_nib = (idx_q == IDXW'(N - 1));

    // Next-state logic: accept in IDLE, walk nibbles in CMP, strobe in DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (gnt0 | gnt1) begin
                    a_d     = gnt1 ? req1_a_i : req0_a_i;
                    b_d     = gnt1 ? req1_b_i : req0_b_i;
                    owner_d = gnt1;
                    ptr_d   = ~gnt1;      // the loser is favoured next time
                    idx_d   = '0;
                    acc_d   = 1'b1;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                acc_d = acc_q & nib_eq;
                if (!nib_eq || last_nib) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; an in-flight compare is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            acc_q   <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Result fields are forced low outside the DONE strobe.
    assign res_valid_o = (state_q == S_DONE);
    assign res_eq_o    = res_valid_o & acc_q;
    assign res_id_o    = res_valid_o & owner_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_eq_arbiter_seq.sv
// Bench for eq_arbiter_seq: a cycle-count reference model checks every cycle,
// directed cases pin latencies/grant order with literal values, then random
// traffic with occasional resets. A second WIDTH=4 instance gets literal checks.
module tb_eq_arbiter_seq;
    localparam int W  = 16;
    localparam int NN = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rdy0, rdy1, rv, req, rid, busy;

    logic         w_v0 = 1'b0, w_v1 = 1'b0;
    logic [3:0]   w_a0 = '0, w_b0 = '0, w_a1 = '0, w_b1 = '0;
    logic         w_rdy0, w_rdy1, w_rv, w_req, w_rid, w_busy;

    eq_arbiter_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_i(rst),
        .req0_valid_i(v0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(rdy0),
        .req1_valid_i(v1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(rdy1),
        .res_valid_o(rv), .res_eq_o(req), .res_id_o(rid), .busy_o(busy)
    );

    eq_arbiter_seq #(.WIDTH(4)) dut4 (
        .clk_i(clk), .reset_i(rst),
        .req0_valid_i(w_v0), .req0_a_i(w_a0), .req0_b_i(w_b0), .req0_ready_o(w_rdy0),
        .req1_valid_i(w_v1), .req1_a_i(w_a1), .req1_b_i(w_b1), .req1_ready_o(w_rdy1),
        .res_valid_o(w_rv), .res_eq_o(w_req), .res_id_o(w_rid), .busy_o(w_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Number of nibbles the compare needs: up to the first mismatch, else all.
    function automatic int calc_k(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < NN; i++)
            if (a[i*4 +: 4] !== b[i*4 +: 4]) return i + 1;
        return NN;
    endfunction

    // Reference model: m_cnt = cycles left until the block is idle again
    // (k CMP cycles + 1 DONE cycle); result strobes when it reaches 1.
    int m_cnt = 0;
    bit m_ptr = 1'b0, m_eq = 1'b0, m_id = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_r0, e_r1, w;
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (m_cnt == 0 && !rst) begin
                if (v0 && v1) begin
                    e_r0 = !m_ptr;
                    e_r1 = m_ptr;
                end else begin
                    e_r0 = v0;
                    e_r1 = v1;
                end
            end
            check("ready0", 32'(rdy0), 32'(e_r0));
            check("ready1", 32'(rdy1), 32'(e_r1));
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("res_valid", 32'(rv), 32'(m_cnt == 1));
            check("res_eq", 32'(req), 32'((m_cnt == 1) && m_eq));
            check("res_id", 32'(rid), 32'((m_cnt == 1) && m_id));
            if (rst) begin
                m_cnt = 0;
                m_ptr = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end else if (e_r0 || e_r1) begin
                w     = e_r1;
                m_id  = w;
                m_ptr = !w;
                m_eq  = w ? (a1 == b1) : (a0 == b0);
                m_cnt = (w ? calc_k(a1, b1) : calc_k(a0, b0)) + 1;
            end
        end
    end

    // One directed compare with literal latency/result expectations.
    task automatic do_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit mutate, input int exp_lat, input bit exp_eq, input string nm);
        int t;
        bit got;
        t = -1;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; end
        for (int n = 0; n < 40 && t < 0; n++) begin
            @(negedge clk);
            if (id ? (rdy1 && v1) : (rdy0 && v0)) t = cyc;
        end
        check({nm, " handshake"}, 32'(t >= 0), 32'd1);
        @(posedge clk); #1;
        if (id) v1 = 1'b0; else v0 = 1'b0;
        if (mutate) a0 = ~a0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got && t >= 0; n++) begin
            @(negedge clk);
            if (rv) begin
                got = 1'b1;
                check({nm, " latency"}, 32'(cyc - t), 32'(exp_lat));
                check({nm, " eq"}, 32'(req), 32'(exp_eq));
                check({nm, " id"}, 32'(rid), 32'(id));
            end
        end
        check({nm, " result seen"}, 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_req4(input logic [3:0] a, input logic [3:0] b, input bit exp_eq, input string nm);
        int t;
        bit got;
        t = -1;
        w_v0 = 1'b1; w_a0 = a; w_b0 = b;
        for (int n = 0; n < 20 && t < 0; n++) begin
            @(negedge clk);
            if (w_rdy0) t = cyc;
        end
        check({nm, " handshake"}, 32'(t >= 0), 32'd1);
        @(posedge clk); #1;
        w_v0 = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got && t >= 0; n++) begin
            @(negedge clk);
            if (w_rv) begin
                got = 1'b1;
                check({nm, " latency"}, 32'(cyc - t), 32'd2);
                check({nm, " eq"}, 32'(w_req), 32'(exp_eq));
            end
        end
        check({nm, " result seen"}, 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int g_id[4];
        int g_t[4];
        int ng, t, t3;
        bit got;
        logic [W-1:0] flip;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset res_valid", 32'(rv), 32'd0);
        check("reset w4 busy", 32'(w_busy), 32'd0);
        @(posedge clk); #1;

        do_req(1'b0, 16'hABCD, 16'hABCD, 1'b0, 5, 1'b1, "equal");
        do_req(1'b1, 16'h1234, 16'h1235, 1'b0, 2, 1'b0, "mismatch nib0");
        do_req(1'b1, 16'h1234, 16'h9234, 1'b0, 5, 1'b0, "mismatch nib3");
        do_req(1'b0, 16'h0C3A, 16'h0C3A, 1'b1, 5, 1'b1, "operand stability");

        // Fairness: both held valid after reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        a0 = 16'h5A5A; b0 = 16'h5A5A; a1 = 16'h3C3C; b1 = 16'h3C3C;
        ng = 0;
        for (int n = 0; n < 60 && ng < 4; n++) begin
            @(negedge clk);
            if ((rdy0 && v0) || (rdy1 && v1)) begin
                g_id[ng] = rdy1 ? 1 : 0;
                g_t[ng]  = cyc;
                ng++;
            end
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        check("fair grant count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
            check("fair grant id", 32'(g_id[i]), 32'(i % 2));
            if (i > 0) check("fair spacing", 32'(g_t[i] - g_t[i-1]), 32'd6);
        end
        repeat (8) @(posedge clk);
        #1;

        // Reset in the middle of a compare.
        v0 = 1'b1; a0 = 16'hABCD; b0 = 16'hABCD;
        t = -1;
        for (int n = 0; n < 20 && t < 0; n++) begin
            @(negedge clk);
            if (rdy0) t = cyc;
        end
        check("rstmid handshake", 32'(t >= 0), 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b1; a1 = 16'h0F0F; b1 = 16'h0F0F;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        t3 = cyc;
        check("rstmid busy after", 32'(busy), 32'd0);
        check("rstmid ready1 first", 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            if (rv) begin
                got = 1'b1;
                check("rstmid first result id", 32'(rid), 32'd1);
                check("rstmid first result latency", 32'(cyc - t3), 32'd5);
            end
        end
        check("rstmid result seen", 32'(got), 32'd1);
        @(posedge clk); #1;

        do_req4(4'h7, 4'h7, 1'b1, "w4 equal");
        do_req4(4'h7, 4'h6, 1'b0, "w4 mismatch");

        // Random traffic; the per-cycle model does the checking.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            v0  = ($urandom_range(0, 2) != 0);
            v1  = ($urandom_range(0, 2) != 0);
            a0  = W'($urandom);
            flip = W'($urandom_range(1, 15));
            b0  = $urandom_range(0, 1) ? a0 : (a0 ^ (flip << (4 * $urandom_range(0, NN-1))));
            a1  = W'($urandom);
            flip = W'($urandom_range(1, 15));
            b1  = $urandom_range(0, 1) ? a1 : (a1 ^ (flip << (4 * $urandom_range(0, NN-1))));
            @(posedge clk); #1;
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
